// File: rtl/display_timing_pkg.sv
// ============================================================================
// display_timing_pkg : shared raster timing constants and beam coordinate types
// Revision: 1.0
// ============================================================================
`default_nettype none

package display_timing_pkg;

    localparam int DEF_H_VISIBLE = 1024;
    localparam int DEF_H_FRONT   = 24;
    localparam int DEF_H_SYNC    = 136;
    localparam int DEF_H_BACK    = 160;
    localparam int DEF_V_VISIBLE = 768;
    localparam int DEF_V_FRONT   = 3;
    localparam int DEF_V_SYNC    = 6;
    localparam int DEF_V_BACK    = 29;

    localparam int COORD_W   = 11;
    localparam int COORD_LIM = 1 << COORD_W;

    typedef logic [COORD_W-1:0] coord_t;
    typedef coord_t [1:0]       beam_pos_t;

    // One extra bit so a window ending exactly at COORD_LIM does not alias to 0.
    function automatic logic in_window(input coord_t v, input int lo, input int len);
        logic [COORD_W:0] v_ext;
        v_ext = {1'b0, v};
        return (v_ext >= (COORD_W+1)'(lo)) && (v_ext < (COORD_W+1)'(lo + len));
    endfunction

endpackage

`default_nettype wire

// File: rtl/electron_beam_positioner_wrap_counter.sv
// ============================================================================
// wrap_counter : enabled up-counter that returns to zero after reaching MAX
// Revision: 1.0
// ============================================================================
`default_nettype none

module wrap_counter
    import display_timing_pkg::*;
#(
    parameter int MAX = 15
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   enable,
    output coord_t count,
    output logic   wrap
);

    coord_t count_q;
    coord_t count_d;

    assign wrap = enable && (count_q == COORD_W'(MAX));

    always_comb begin
        count_d = count_q;
        if (wrap) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/electron_beam_positioner.sv
// ============================================================================
// electron_beam_positioner : raster beam coordinates plus horizontal/vertical sync
// Revision: 1.0
// ============================================================================
`default_nettype none

module electron_beam_positioner
    import display_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic      clock,
    input  logic      reset,
    output beam_pos_t instantaneous_beam_position,
    output logic      beam2left_signal,
    output logic      beam2top_signal
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > COORD_LIM || V_TOTAL > COORD_LIM) begin : g_bad_totals
            $error("electron_beam_positioner: frame totals exceed coordinate range");
        end
    endgenerate

    coord_t x_cnt;
    coord_t y_cnt;
    logic   x_wrap;
    logic   y_wrap;

    wrap_counter #(.MAX(H_TOTAL - 1)) u_x_counter (
        .clock  (clock),
        .reset  (reset),
        .enable (1'b1),
        .count  (x_cnt),
        .wrap   (x_wrap)
    );

    // Row advances only on the line wrap, so its own wrap marks the frame wrap.
    wrap_counter #(.MAX(V_TOTAL - 1)) u_y_counter (
        .clock  (clock),
        .reset  (reset),
        .enable (x_wrap),
        .count  (y_cnt),
        .wrap   (y_wrap)
    );

    assign instantaneous_beam_position[0] = x_cnt;
    assign instantaneous_beam_position[1] = y_cnt;

    assign beam2left_signal = in_window(x_cnt, H_VISIBLE + H_FRONT, H_SYNC);
    assign beam2top_signal  = in_window(y_cnt, V_VISIBLE + V_FRONT, V_SYNC);

    logic unused_ok;
    assign unused_ok = y_wrap;

endmodule

`default_nettype wire

// File: tb/tb_electron_beam_positioner.sv
// ============================================================================
// tb_electron_beam_positioner : directed checks of default and small raster timing
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_electron_beam_positioner;
    import display_timing_pkg::*;

    logic      clock;
    logic      reset;
    beam_pos_t pos_d;
    logic      hs_d, vs_d;
    beam_pos_t pos_s;
    logic      hs_s, vs_s;

    int compared = 0;
    int mismatched = 0;

    int mx, my, sx, sy, px, py, psx, psy;
    int rise_x = -1, fall_x = -1, hs_cnt = 0;
    logic prev_hs = 1'b0;

    electron_beam_positioner dut (
        .clock                       (clock),
        .reset                       (reset),
        .instantaneous_beam_position (pos_d),
        .beam2left_signal            (hs_d),
        .beam2top_signal             (vs_d)
    );

    electron_beam_positioner #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut_s (
        .clock                       (clock),
        .reset                       (reset),
        .instantaneous_beam_position (pos_s),
        .beam2left_signal            (hs_s),
        .beam2top_signal             (vs_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("dflt_x",  32'(pos_d[0]), 32'(mx));
        chk("dflt_y",  32'(pos_d[1]), 32'(my));
        chk("dflt_hs", 32'(hs_d), 32'((mx >= 1048 && mx < 1184) ? 1 : 0));
        chk("dflt_vs", 32'(vs_d), 32'((my >= 771 && my < 777) ? 1 : 0));
        chk("small_x",  32'(pos_s[0]), 32'(sx));
        chk("small_y",  32'(pos_s[1]), 32'(sy));
        chk("small_hs", 32'(hs_s), 32'((sx >= 10 && sx < 12) ? 1 : 0));
        chk("small_vs", 32'(vs_s), 32'((sy >= 7 && sy < 9) ? 1 : 0));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        px = mx; py = my; psx = sx; psy = sy;
        if (mx == 1343) begin
            mx = 0;
            my = (my == 805) ? 0 : my + 1;
        end else begin
            mx = mx + 1;
        end
        if (sx == 13) begin
            sx = 0;
            sy = (sy == 9) ? 0 : sy + 1;
        end else begin
            sx = sx + 1;
        end
        chk_all();
        chk("small_x_range", 32'((pos_s[0] <= 13) ? 1 : 0), 32'd1);
        chk("small_y_range", 32'((pos_s[1] <= 9) ? 1 : 0), 32'd1);
        if (px == 1343 && py == 0) begin
            chk("line_wrap_x",  32'(pos_d[0]), 32'd0);
            chk("line_wrap_y",  32'(pos_d[1]), 32'd1);
            chk("line_wrap_hs", 32'(hs_d), 32'd0);
        end
        if (psx == 13 && psy == 9) begin
            chk("frame_wrap_x", 32'(pos_s[0]), 32'd0);
            chk("frame_wrap_y", 32'(pos_s[1]), 32'd0);
        end
        if (my == 0) begin
            if (hs_d && !prev_hs) rise_x = int'(pos_d[0]);
            if (!hs_d && prev_hs) fall_x = int'(pos_d[0]);
            if (hs_d) hs_cnt++;
        end
        prev_hs = hs_d;
    endtask

    initial begin
        mx = 0; my = 0; sx = 0; sy = 0;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk_all();

        @(negedge clock);
        reset = 1'b1;
        step();
        step();
        step();

        repeat (1500) step();
        chk("hs_rise_x", 32'(rise_x), 32'd1048);
        chk("hs_fall_x", 32'(fall_x), 32'd1184);
        chk("hs_width",  32'(hs_cnt), 32'd136);

        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        mx = 0; my = 0; sx = 0; sy = 0;
        chk_all();
        @(negedge clock);
        chk_all();
        reset = 1'b1;
        step();
        step();
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
